// File: rtl/fpu_pkg.sv
// fpu_pkg: definitions shared by the FPU operand queue files.
//   CMD_W          width of the FPU operation code
//   fpu_cmd_e      operation code encoding (the queue passes codes through untouched)
//   issue_state_e  states of the issue FSM that offers queued requests to the FPU
package fpu_pkg;

  localparam int CMD_W = 4;

  typedef enum logic [CMD_W-1:0] {
    CMD_ADD  = 4'h0,
    CMD_SUB  = 4'h1,
    CMD_MUL  = 4'h2,
    CMD_DIV  = 4'h3,
    CMD_SQRT = 4'h4,
    CMD_CMP  = 4'h5,
    CMD_I2F  = 4'h6,
    CMD_F2I  = 4'h7
  } fpu_cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OFFER = 2'd1,
    ST_GAP   = 2'd2
  } issue_state_e;

endpackage

// File: rtl/fpu_operand_queue_if.sv
// fpu_operand_queue_if: producer side, FPU side and status of the operand queue.
//   producer : in_valid, in_ready, in_a, in_b, in_command
//   FPU      : input_rdy, input_ack, data_a, data_b, command
//   status   : occupancy, empty, full
// Handshakes: a producer word moves on a rising edge where in_valid && in_ready;
// a request moves to the FPU on a rising edge where input_rdy && input_ack.
// in_ready and input_rdy depend only on registered state, never on in_valid or
// input_ack, so either side may look at them before deciding what to drive.
// Modports: slave = the queue, master = whoever drives producer and FPU inputs.
interface fpu_operand_queue_if #(
  parameter int bitness = 32,
  parameter int depth   = 4
);
  localparam int OCC_W = $clog2(depth) + 1;

  logic                      in_valid;
  logic                      in_ready;
  logic [bitness-1:0]        in_a;
  logic [bitness-1:0]        in_b;
  logic [fpu_pkg::CMD_W-1:0] in_command;

  logic                      input_rdy;
  logic                      input_ack;
  logic [bitness-1:0]        data_a;
  logic [bitness-1:0]        data_b;
  logic [fpu_pkg::CMD_W-1:0] command;

  logic [OCC_W-1:0]          occupancy;
  logic                      empty;
  logic                      full;

  modport slave (
    input  in_valid, in_a, in_b, in_command, input_ack,
    output in_ready, input_rdy, data_a, data_b, command, occupancy, empty, full
  );

  modport master (
    output in_valid, in_a, in_b, in_command, input_ack,
    input  in_ready, input_rdy, data_a, data_b, command, occupancy, empty, full
  );

endinterface

// File: rtl/fpu_queue_mem.sv
// fpu_queue_mem: storage array of the operand queue.
//   i_clk    clock
//   i_we     write enable (one synchronous write port)
//   i_waddr  write address
//   i_wdata  write data
//   i_raddr  read address (asynchronous read port)
//   o_rdata  read data
// Contents are never reset.
module fpu_queue_mem #(
  parameter int WIDTH = 68,
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/fpu_operand_queue.sv
// fpu_operand_queue: circular-buffer queue between an operand producer and an FPU.
//   clock         rising-edge clock
//   reset         synchronous, active-high reset
//   bus           fpu_operand_queue_if.slave (producer push, FPU issue, status)
//   o_dbg_state   current issue FSM state
//   issued_count  16-bit wrapping count of transfers to the FPU; present only
//                 when FPU_QUEUE_COUNT_EN is defined
// Issue FSM: IDLE waits for an entry, OFFER presents the head until the FPU
// acknowledges it, GAP is one dead cycle after every transfer.
module fpu_operand_queue
  import fpu_pkg::*;
#(
  parameter int bitness = 32,
  parameter int depth   = 4
) (
  input  logic                clock,
  input  logic                reset,
  fpu_operand_queue_if.slave  bus,
  output issue_state_e        o_dbg_state
`ifdef FPU_QUEUE_COUNT_EN
  ,
  output logic [15:0]         issued_count
`endif
);

  localparam int AW    = $clog2(depth);
  localparam int OCC_W = AW + 1;
  localparam int EW    = 2 * bitness + CMD_W;
  localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(depth);

  issue_state_e     r_state;
  issue_state_e     w_state_next;
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [OCC_W-1:0] r_occ;
  logic [OCC_W-1:0] w_occ_next;
  logic             w_full;
  logic             w_push;
  logic             w_pop;
  logic             w_input_rdy;
  logic [EW-1:0]    w_wdata;
  logic [EW-1:0]    w_rdata;

  assign w_full = (r_occ == FULL_OCC);
  // Nothing moves on a reset edge, even if the FPU acknowledges.
  assign w_push = bus.in_valid && !w_full && !reset;
  assign w_pop  = (r_state == ST_OFFER) && bus.input_ack && !reset;

  always_comb begin
    w_occ_next = r_occ;
    case ({w_push, w_pop})
      2'b10:   w_occ_next = r_occ + 1'b1;
      2'b01:   w_occ_next = r_occ - 1'b1;
      default: w_occ_next = r_occ;
    endcase
  end

  // Pointers and occupancy. Depth is a power of two, so the pointers wrap
  // from depth-1 to 0 by plain overflow.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_occ  <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      r_occ <= w_occ_next;
    end
  end

  // Issue FSM: state register.
  always_ff @(posedge clock) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  // Issue FSM: next state. IDLE also looks at the push on this edge so a word
  // written into an empty queue is offered on the very next cycle.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if ((r_occ != '0) || w_push) w_state_next = ST_OFFER;
      ST_OFFER: if (bus.input_ack)           w_state_next = ST_GAP;
      ST_GAP:   w_state_next = (r_occ != '0) ? ST_OFFER : ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  // Issue FSM: outputs.
  always_comb begin
    w_input_rdy = 1'b0;
    if (r_state == ST_OFFER) w_input_rdy = 1'b1;
  end

  assign w_wdata = {bus.in_a, bus.in_b, bus.in_command};

  fpu_queue_mem #(
    .WIDTH (EW),
    .DEPTH (depth)
  ) u_mem (
    .i_clk   (clock),
    .i_we    (w_push),
    .i_waddr (r_wptr),
    .i_wdata (w_wdata),
    .i_raddr (r_rptr),
    .o_rdata (w_rdata)
  );

  // The read port follows the read pointer, so the head stays put while OFFER
  // waits for the acknowledge.
  assign bus.data_a    = w_rdata[EW-1 -: bitness];
  assign bus.data_b    = w_rdata[CMD_W +: bitness];
  assign bus.command   = w_rdata[CMD_W-1:0];
  assign bus.input_rdy = w_input_rdy;
  assign bus.in_ready  = !w_full;
  assign bus.occupancy = r_occ;
  assign bus.empty     = (r_occ == '0);
  assign bus.full      = w_full;
  assign o_dbg_state   = r_state;

`ifdef FPU_QUEUE_COUNT_EN
  logic [15:0] r_issued_count;

  always_ff @(posedge clock) begin
    if (reset)      r_issued_count <= '0;
    else if (w_pop) r_issued_count <= r_issued_count + 16'd1;
  end

  assign issued_count = r_issued_count;
`endif

endmodule

// File: tb/tb_fpu_operand_queue.sv
// tb_fpu_operand_queue: self-checking bench for fpu_operand_queue (depth 4, 32-bit).
// Build with FPU_QUEUE_COUNT_EN defined to also exercise issued_count.
module tb_fpu_operand_queue;
  import fpu_pkg::*;

  localparam int BITNESS = 32;
  localparam int DEPTH   = 4;
  localparam int OCC_W   = $clog2(DEPTH) + 1;
  localparam int EW      = 2 * BITNESS + CMD_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  issue_state_e dbg_state;
`ifdef FPU_QUEUE_COUNT_EN
  logic [15:0] issued_count;
`endif

  int total  = 0;
  int bad    = 0;
  int n_xfer = 0;

  fpu_operand_queue_if #(.bitness(BITNESS), .depth(DEPTH)) bus ();

  fpu_operand_queue #(.bitness(BITNESS), .depth(DEPTH)) dut (
    .clock       (clk),
    .reset       (rst),
    .bus         (bus),
    .o_dbg_state (dbg_state)
`ifdef FPU_QUEUE_COUNT_EN
    ,
    .issued_count(issued_count)
`endif
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- scoreboard / reference model ----------------
  // The model is a queue of stored words. The FPU side must offer the oldest
  // word whenever one is stored, except in the dead cycle after a transfer and
  // in the idle cycle that follows a dead cycle which found the queue empty.
  logic [EW-1:0] exp_q[$];
  bit in_gap      = 1'b0;
  bit forced_idle = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      in_gap      = 1'b0;
      forced_idle = 1'b0;
    end else begin
      int   sz;
      logic exp_rdy;
      logic xfer;
      sz      = exp_q.size();
      exp_rdy = (sz > 0) && !in_gap && !forced_idle;
      total++;
      if (bus.occupancy !== OCC_W'(sz)) begin
        bad++;
        $display("FAIL sb_occupancy t=%0t: got %0d expected %0d", $time, bus.occupancy, sz);
      end
      total++;
      if (bus.in_ready !== (sz < DEPTH)) begin
        bad++;
        $display("FAIL sb_in_ready t=%0t: got %b expected %b", $time, bus.in_ready, (sz < DEPTH));
      end
      total++;
      if (bus.empty !== (sz == 0) || bus.full !== (sz == DEPTH)) begin
        bad++;
        $display("FAIL sb_empty_full t=%0t: got %b/%b expected %b/%b", $time,
                 bus.empty, bus.full, (sz == 0), (sz == DEPTH));
      end
      total++;
      if (bus.input_rdy !== exp_rdy) begin
        bad++;
        $display("FAIL sb_input_rdy t=%0t: got %b expected %b", $time, bus.input_rdy, exp_rdy);
      end
      if (exp_rdy) begin
        total++;
        if ({bus.data_a, bus.data_b, bus.command} !== exp_q[0]) begin
          bad++;
          $display("FAIL sb_head t=%0t: got %h expected %h", $time,
                   {bus.data_a, bus.data_b, bus.command}, exp_q[0]);
        end
      end
      xfer        = exp_rdy && bus.input_ack;
      forced_idle = in_gap && (sz == 0);
      in_gap      = xfer;
      if (xfer) begin
        void'(exp_q.pop_front());
        n_xfer++;
      end
      if (bus.in_valid && (sz < DEPTH))
        exp_q.push_back({bus.in_a, bus.in_b, bus.in_command});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(output bit ok);
    bus.in_valid  = 1'b0;
    bus.input_ack = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (bus.occupancy == '0 && dbg_state == ST_IDLE) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    bus.input_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    total++;
    if (bus.in_ready !== 1'b1 || bus.empty !== 1'b1 || bus.full !== 1'b0) begin
      bad++;
      $display("FAIL reset_flags: got rdy=%b empty=%b full=%b expected 1/1/0",
               bus.in_ready, bus.empty, bus.full);
    end
    total++;
    if (bus.occupancy !== '0 || bus.input_rdy !== 1'b0) begin
      bad++;
      $display("FAIL reset_occ: got occ=%0d input_rdy=%b expected 0/0", bus.occupancy, bus.input_rdy);
    end
    total++;
    if (dbg_state !== ST_IDLE) begin
      bad++;
      $display("FAIL reset_state: got %0d expected %0d", dbg_state, ST_IDLE);
    end
  endtask

  task automatic test_single_op();
    bus.in_valid   = 1'b1;
    bus.in_a       = 32'h3F80_0000;
    bus.in_b       = 32'h4000_0000;
    bus.in_command = 4'h4;
    bus.input_ack  = 1'b1;
    step();  // cycle 1
    bus.in_valid = 1'b0;
    total++;
    if (bus.input_rdy !== 1'b1) begin
      bad++;
      $display("FAIL single_rdy_c1: got %b expected 1", bus.input_rdy);
    end
    total++;
    if (bus.data_a !== 32'h3F80_0000 || bus.data_b !== 32'h4000_0000 || bus.command !== 4'h4) begin
      bad++;
      $display("FAIL single_data_c1: got %h %h %h expected 3f800000 40000000 4",
               bus.data_a, bus.data_b, bus.command);
    end
    step();  // cycle 2
    total++;
    if (bus.input_rdy !== 1'b0) begin
      bad++;
      $display("FAIL single_rdy_c2: got %b expected 0", bus.input_rdy);
    end
    step();  // cycle 3
    total++;
    if (dbg_state !== ST_IDLE || bus.empty !== 1'b1) begin
      bad++;
      $display("FAIL single_idle_c3: got state=%0d empty=%b expected %0d/1", dbg_state, bus.empty, ST_IDLE);
    end
    bus.input_ack = 1'b0;
  endtask

  task automatic test_fill_stall();
    bit ok;
    bus.input_ack = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.in_valid   = 1'b1;
      bus.in_a       = 32'h1000_0000 + 32'(i);
      bus.in_b       = $urandom;
      bus.in_command = 4'(i + 1);
      if (i < 4) step();
    end
    total++;
    if (bus.full !== 1'b1 || bus.in_ready !== 1'b0 || bus.occupancy !== 3'd4) begin
      bad++;
      $display("FAIL fill_full: got full=%b in_ready=%b occ=%0d expected 1/0/4",
               bus.full, bus.in_ready, bus.occupancy);
    end
    step();
    step();
    total++;
    if (bus.occupancy !== 3'd4) begin
      bad++;
      $display("FAIL fill_hold: got occ=%0d expected 4", bus.occupancy);
    end
    bus.input_ack = 1'b1;
    step();
    bus.input_ack = 1'b0;
    total++;
    if (bus.occupancy !== 3'd3) begin
      bad++;
      $display("FAIL fill_pop: got occ=%0d expected 3", bus.occupancy);
    end
    step();
    bus.in_valid = 1'b0;
    total++;
    if (bus.occupancy !== 3'd4 || bus.full !== 1'b1) begin
      bad++;
      $display("FAIL fill_fifth: got occ=%0d full=%b expected 4/1", bus.occupancy, bus.full);
    end
    drain(ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL fill_drain: got timeout expected empty idle queue");
    end
  endtask

  task automatic test_simul_push_pop();
    bit ok;
    logic [31:0] second_a;
    second_a = 32'h2000_0002;
    bus.input_ack  = 1'b0;
    bus.in_valid   = 1'b1;
    bus.in_a       = 32'h2000_0001;
    bus.in_b       = $urandom;
    bus.in_command = 4'h1;
    step();
    bus.in_a       = second_a;
    bus.in_b       = $urandom;
    bus.in_command = 4'h2;
    step();
    total++;
    if (bus.occupancy !== 3'd2) begin
      bad++;
      $display("FAIL simul_pre: got occ=%0d expected 2", bus.occupancy);
    end
    bus.in_a       = 32'h2000_0003;
    bus.in_b       = $urandom;
    bus.in_command = 4'h3;
    bus.input_ack  = 1'b1;
    step();
    bus.in_valid  = 1'b0;
    bus.input_ack = 1'b0;
    total++;
    if (bus.occupancy !== 3'd2) begin
      bad++;
      $display("FAIL simul_occ: got occ=%0d expected 2", bus.occupancy);
    end
    step();
    total++;
    if (bus.input_rdy !== 1'b1 || bus.data_a !== second_a) begin
      bad++;
      $display("FAIL simul_next: got rdy=%b a=%h expected 1/%h", bus.input_rdy, bus.data_a, second_a);
    end
    drain(ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL simul_drain: got timeout expected empty idle queue");
    end
  endtask

  task automatic test_order_wrap(input int round);
    bit ok;
    bit prod_done;
    int start_xfer;
    prod_done  = 1'b0;
    start_xfer = n_xfer;
    fork
      begin : producer
        int sent;
        logic accepted;
        sent = 0;
        for (int g = 0; g < 2000 && sent < 10; g++) begin
          if ($urandom_range(0, 3) == 0) begin
            bus.in_valid = 1'b0;
            step();
          end else begin
            bus.in_valid   = 1'b1;
            bus.in_a       = 32'hC000_0000 + 32'(round * 16 + sent);
            bus.in_b       = $urandom;
            bus.in_command = 4'($urandom_range(0, 15));
            accepted       = bus.in_ready;
            step();
            if (accepted) sent++;
          end
        end
        bus.in_valid = 1'b0;
        prod_done    = 1'b1;
      end
      begin : consumer
        for (int g = 0; g < 4000 && !prod_done; g++) begin
          bus.input_ack = ($urandom_range(0, 2) == 0);
          step();
        end
        bus.input_ack = 1'b0;
      end
    join
    drain(ok);
    total++;
    if (!ok || exp_q.size() != 0) begin
      bad++;
      $display("FAIL order_drain: got ok=%b left=%0d expected 1/0", ok, exp_q.size());
    end
    total++;
    if (n_xfer - start_xfer != 10) begin
      bad++;
      $display("FAIL order_count: got %0d transfers expected 10", n_xfer - start_xfer);
    end
  endtask

  task automatic test_reset_offer();
    bus.input_ack = 1'b0;
    bus.in_valid  = 1'b1;
    for (int i = 0; i < 2; i++) begin
      bus.in_a       = 32'h5000_0000 + 32'(i);
      bus.in_b       = $urandom;
      bus.in_command = 4'(i);
      step();
    end
    bus.in_valid = 1'b0;
    total++;
    if (bus.input_rdy !== 1'b1) begin
      bad++;
      $display("FAIL rstoffer_pre: got rdy=%b expected 1", bus.input_rdy);
    end
    rst           = 1'b1;
    bus.input_ack = 1'b1;
    step();
    rst           = 1'b0;
    bus.input_ack = 1'b0;
    total++;
    if (bus.occupancy !== '0 || bus.input_rdy !== 1'b0 || bus.in_ready !== 1'b1 || dbg_state !== ST_IDLE) begin
      bad++;
      $display("FAIL rstoffer_post: got occ=%0d rdy=%b in_ready=%b state=%0d expected 0/0/1/%0d",
               bus.occupancy, bus.input_rdy, bus.in_ready, dbg_state, ST_IDLE);
    end
`ifdef FPU_QUEUE_COUNT_EN
    total++;
    if (issued_count !== 16'd0) begin
      bad++;
      $display("FAIL rstoffer_count: got %h expected 0000", issued_count);
    end
`endif
    step();
    total++;
    if (bus.input_rdy !== 1'b0 || bus.empty !== 1'b1) begin
      bad++;
      $display("FAIL rstoffer_after: got rdy=%b empty=%b expected 0/1", bus.input_rdy, bus.empty);
    end
  endtask

`ifdef FPU_QUEUE_COUNT_EN
  task automatic test_issue_count();
    logic [15:0] exp_cnt;
    force dut.r_issued_count = 16'hFFFE;
    step();
    release dut.r_issued_count;
    exp_cnt = 16'hFFFE;
    for (int k = 0; k < 3; k++) begin
      bus.in_valid   = 1'b1;
      bus.in_a       = 32'h7000_0000 + 32'(k);
      bus.in_b       = $urandom;
      bus.in_command = 4'h2;
      bus.input_ack  = 1'b1;
      step();  // offered
      bus.in_valid = 1'b0;
      step();  // transferred
      exp_cnt = exp_cnt + 16'd1;
      total++;
      if (issued_count !== exp_cnt) begin
        bad++;
        $display("FAIL issue_count_%0d: got %h expected %h", k, issued_count, exp_cnt);
      end
      bus.input_ack = 1'b0;
      step();
    end
  endtask
`endif

  // ---------------- sequence and final report ----------------
  initial begin
    bus.in_valid   = 1'b0;
    bus.in_a       = '0;
    bus.in_b       = '0;
    bus.in_command = '0;
    bus.input_ack  = 1'b0;
    test_reset();
    test_single_op();
    test_fill_stall();
    test_simul_push_pop();
    for (int r = 0; r < 3; r++) test_order_wrap(r);
    test_reset_offer();
`ifdef FPU_QUEUE_COUNT_EN
    test_issue_count();
`endif
    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
